// File: rtl/led_sequencer_pkg.sv
// Shared constants, ctrl bit layout and FSM state type for the LED sequencer.
package led_sequencer_pkg;

  localparam logic [11:0] LEDADDR  = 12'h060;
  localparam logic [11:0] CTRLADDR = 12'h064;
  localparam logic [11:0] PERADDR  = 12'h068;
  localparam logic [11:0] PATBASE  = 12'h080;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int CTRL_LOOP_BIT = 1;
  localparam int CTRL_LAST_LSB = 4;
  localparam int CTRL_LAST_MSB = 6;

  localparam int NUM_PAT = 8;
  localparam int PAT_W   = 24;
  localparam int CNT_W   = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Counter reload value for a step: max(period,1) - 1.
  function automatic logic [CNT_W-1:0] period_load(input logic [CNT_W-1:0] period);
    return (period == '0) ? '0 : period - 1'b1;
  endfunction

endpackage

// File: rtl/led_seq_timer.sv
// Step timer: 24-bit down-counter with synchronous load, count enable and zero flag.
module led_seq_timer
  import led_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; otherwise count down while enabled and not yet at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer sitting between the CPU device bus and the LED register.
// CPU writes are forwarded one cycle later and always win; the sequencer only
// issues its own LED write in an EMIT cycle with no CPU write present.
module led_sequencer #(
  parameter logic [11:0] LEDADDR  = led_sequencer_pkg::LEDADDR,
  parameter logic [11:0] CTRLADDR = led_sequencer_pkg::CTRLADDR,
  parameter logic [11:0] PERADDR  = led_sequencer_pkg::PERADDR,
  parameter logic [11:0] PATBASE  = led_sequencer_pkg::PATBASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dv_wr_e,
  input  logic [11:0] dv_addr,
  input  logic [31:0] data_fromcpu,
  output logic        dvo_wr_e,
  output logic [11:0] dvo_addr,
  output logic [31:0] dvo_data,
  output logic        seq_busy,
  output logic [2:0]  seq_idx,
  output logic        seq_done
);

  import led_sequencer_pkg::*;

  // The ctrl run bit is carried by the FSM itself: run=1 exactly when the
  // state is not IDLE, so only loop and last index need separate storage.
  logic             ctrl_loop;
  logic [2:0]       ctrl_last;
  logic [CNT_W-1:0] period;
  logic [PAT_W-1:0] pat [NUM_PAT];

  state_t     state, state_nx;
  logic [2:0] idx, idx_nx;
  logic       emit, done_nx, tmr_en, tmr_zero;
  logic       wr_ctrl, wr_per, wr_pat;

  assign wr_ctrl = dv_wr_e && (dv_addr == CTRLADDR);
  assign wr_per  = dv_wr_e && (dv_addr == PERADDR);
  assign wr_pat  = dv_wr_e && (dv_addr[11:5] == PATBASE[11:5]) && (dv_addr[1:0] == 2'b00);

  // Configuration registers written by the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_loop <= 1'b0;
      ctrl_last <= '0;
      period    <= '0;
      for (int i = 0; i < NUM_PAT; i++) pat[i] <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_loop <= data_fromcpu[CTRL_LOOP_BIT];
        ctrl_last <= data_fromcpu[CTRL_LAST_MSB:CTRL_LAST_LSB];
      end
      if (wr_per) period <= data_fromcpu[CNT_W-1:0];
      if (wr_pat) pat[dv_addr[4:2]] <= data_fromcpu[PAT_W-1:0];
    end
  end

  // Next-state logic; a ctrl write overrides whatever the sequence was doing.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    emit     = 1'b0;
    done_nx  = 1'b0;
    if (wr_ctrl) begin
      if (data_fromcpu[CTRL_RUN_BIT]) begin
        state_nx = EMIT;
        idx_nx   = '0;
      end else begin
        state_nx = IDLE;
      end
    end else begin
      case (state)
        EMIT: begin
          if (!dv_wr_e) begin
            emit     = 1'b1;
            state_nx = WAIT;
          end
        end
        WAIT: begin
          if (tmr_zero) begin
            if (idx != ctrl_last) begin
              idx_nx   = idx + 1'b1;
              state_nx = EMIT;
            end else if (ctrl_loop) begin
              idx_nx   = '0;
              state_nx = EMIT;
            end else begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state, pattern index and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      seq_done <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      seq_done <= done_nx;
    end
  end

  // Output bus: CPU write first, then a sequencer emit; address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvo_wr_e <= 1'b0;
      dvo_addr <= '0;
      dvo_data <= '0;
    end else if (dv_wr_e) begin
      dvo_wr_e <= 1'b1;
      dvo_addr <= dv_addr;
      dvo_data <= data_fromcpu;
    end else if (emit) begin
      dvo_wr_e <= 1'b1;
      dvo_addr <= LEDADDR;
      dvo_data <= {8'h00, pat[idx]};
    end else begin
      dvo_wr_e <= 1'b0;
    end
  end

  assign tmr_en = (state == WAIT);

  led_seq_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (emit),
    .load_val (period_load(period)),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  assign seq_busy = (state != IDLE);
  assign seq_idx  = idx;

endmodule

// File: tb/tb_led_sequencer.sv
// Testbench for led_sequencer: vector table, directed corner sequences and
// random traffic checked against a cycle-count reference model.
module tb_led_sequencer;

  localparam logic [11:0] A_LED  = 12'h060;
  localparam logic [11:0] A_CTRL = 12'h064;
  localparam logic [11:0] A_PER  = 12'h068;
  localparam logic [11:0] A_PAT  = 12'h080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv_wr_e = 1'b0;
  logic [11:0] dv_addr = '0;
  logic [31:0] data_fromcpu = '0;
  logic        dvo_wr_e;
  logic [11:0] dvo_addr;
  logic [31:0] dvo_data;
  logic        seq_busy;
  logic [2:0]  seq_idx;
  logic        seq_done;

  always #5 clk = ~clk;

  led_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dv_wr_e      (dv_wr_e),
    .dv_addr      (dv_addr),
    .data_fromcpu (data_fromcpu),
    .dvo_wr_e     (dvo_wr_e),
    .dvo_addr     (dvo_addr),
    .dvo_data     (dvo_data),
    .seq_busy     (seq_busy),
    .seq_idx      (seq_idx),
    .seq_done     (seq_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs_act();
    return {14'h0, dvo_wr_e, dvo_addr, dvo_data, seq_busy, seq_idx, seq_done};
  endfunction

  // Reference model: an integer countdown to the next due emit, not a state machine.
  logic [23:0] m_pat [8];
  logic [23:0] m_per;
  logic [2:0]  m_last, m_idx;
  bit          m_loop, m_run, m_due, m_done;
  int          m_left;
  logic        e_wr;
  logic [11:0] e_addr;
  logic [31:0] e_data;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pat[i] = '0;
    m_per = '0; m_last = '0; m_idx = '0;
    m_loop = 0; m_run = 0; m_due = 0; m_done = 0; m_left = 0;
    e_wr = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_step(input logic wr, input logic [11:0] a, input logic [31:0] d);
    bit is_ctrl, is_pat;
    int pidx;
    is_ctrl = wr && (a == A_CTRL);
    is_pat  = wr && (a >= 12'h080) && (a < 12'h0A0) && ((a % 4) == 0);
    pidx    = (int'(a) - 'h80) / 4;
    m_done  = 0;
    if (wr) begin
      e_wr = 1; e_addr = a; e_data = d;
    end else if (m_run && m_due) begin
      e_wr = 1; e_addr = A_LED; e_data = {8'h00, m_pat[m_idx]};
    end else begin
      e_wr = 0;
    end
    if (is_ctrl) begin
      m_last = d[6:4];
      m_loop = d[1];
      m_run  = d[0];
      if (d[0]) begin
        m_idx = '0;
        m_due = 1;
      end
    end else if (m_run) begin
      if (m_due) begin
        if (!wr) begin
          m_due  = 0;
          m_left = (m_per == 0) ? 1 : int'(m_per);
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_idx != m_last) begin
            m_idx = m_idx + 3'd1;
            m_due = 1;
          end else if (m_loop) begin
            m_idx = '0;
            m_due = 1;
          end else begin
            m_run  = 0;
            m_done = 1;
          end
        end
      end
    end
    if (wr && (a == A_PER)) m_per = d[23:0];
    if (is_pat) m_pat[pidx] = d[23:0];
  endtask

  task automatic cyc(input logic wr, input logic [11:0] a, input logic [31:0] d, input string name);
    dv_wr_e = wr; dv_addr = a; data_fromcpu = d;
    model_step(wr, a, d);
    @(posedge clk); #1;
    check(name, outs_act(), {14'h0, e_wr, e_addr, e_data, m_run, m_idx, m_done});
    dv_wr_e = 1'b0; dv_addr = '0; data_fromcpu = '0;
  endtask

  task automatic do_reset();
    dv_wr_e = 1'b0; dv_addr = '0; data_fromcpu = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic setup(input logic [31:0] per, input logic [31:0] ctrl, input string name);
    cyc(1'b1, A_PAT,        32'h1, name);
    cyc(1'b1, A_PAT + 12'd4, 32'h2, name);
    cyc(1'b1, A_PAT + 12'd8, 32'h4, name);
    cyc(1'b1, A_PER,         per,   name);
    cyc(1'b1, A_CTRL,        ctrl,  name);
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic        e_wr;
    logic [11:0] e_addr;
    logic [31:0] e_data;
    logic        e_busy;
    logic [2:0]  e_idx;
    logic        e_done;
  } vec_t;

  vec_t tbl [18];
  logic [31:0] got_q [$];
  int          at_q [$];
  int          exp_loop [5] = '{1, 2, 4, 1, 2};
  int          writes;
  bit          found;
  logic [31:0] got;

  initial begin
    // Basic run: pat 1/2/4, period 3, last 2, run -> emits 4 cycles apart, then done.
    tbl[0]  = '{1'b1, 12'h080, 32'h1,  1'b1, 12'h080, 32'h1,  1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 12'h084, 32'h2,  1'b1, 12'h084, 32'h2,  1'b0, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 12'h088, 32'h4,  1'b1, 12'h088, 32'h4,  1'b0, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 12'h068, 32'h3,  1'b1, 12'h068, 32'h3,  1'b0, 3'd0, 1'b0};
    tbl[4]  = '{1'b1, 12'h064, 32'h21, 1'b1, 12'h064, 32'h21, 1'b1, 3'd0, 1'b0};
    tbl[5]  = '{1'b0, 12'h000, 32'h0,  1'b1, 12'h060, 32'h1,  1'b1, 3'd0, 1'b0};
    tbl[6]  = '{1'b0, 12'h000, 32'h0,  1'b0, 12'h060, 32'h1,  1'b1, 3'd0, 1'b0};
    tbl[7]  = '{1'b0, 12'h000, 32'h0,  1'b0, 12'h060, 32'h1,  1'b1, 3'd0, 1'b0};
    tbl[8]  = '{1'b0, 12'h000, 32'h0,  1'b0, 12'h060, 32'h1,  1'b1, 3'd1, 1'b0};
    tbl[9]  = '{1'b0, 12'h000, 32'h0,  1'b1, 12'h060, 32'h2,  1'b1, 3'd1, 1'b0};
    tbl[10] = '{1'b0, 12'h000, 32'h0,  1'b0, 12'h060, 32'h2,  1'b1, 3'd1, 1'b0};
    tbl[11] = '{1'b0, 12'h000, 32'h0,  1'b0, 12'h060, 32'h2,  1'b1, 3'd1, 1'b0};
    tbl[12] = '{1'b0, 12'h000, 32'h0,  1'b0, 12'h060, 32'h2,  1'b1, 3'd2, 1'b0};
    tbl[13] = '{1'b0, 12'h000, 32'h0,  1'b1, 12'h060, 32'h4,  1'b1, 3'd2, 1'b0};
    tbl[14] = '{1'b0, 12'h000, 32'h0,  1'b0, 12'h060, 32'h4,  1'b1, 3'd2, 1'b0};
    tbl[15] = '{1'b0, 12'h000, 32'h0,  1'b0, 12'h060, 32'h4,  1'b1, 3'd2, 1'b0};
    tbl[16] = '{1'b0, 12'h000, 32'h0,  1'b0, 12'h060, 32'h4,  1'b0, 3'd2, 1'b1};
    tbl[17] = '{1'b0, 12'h000, 32'h0,  1'b0, 12'h060, 32'h4,  1'b0, 3'd2, 1'b0};

    do_reset();
    check("reset_state", outs_act(), 64'h0);

    for (int i = 0; i < 18; i++) begin
      dv_wr_e = tbl[i].wr; dv_addr = tbl[i].addr; data_fromcpu = tbl[i].data;
      @(posedge clk); #1;
      check($sformatf("table[%0d]", i), outs_act(),
            {14'h0, tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_data, tbl[i].e_busy, tbl[i].e_idx, tbl[i].e_done});
    end

    // Contention: three CPU writes over the EMIT cycle, pattern follows one cycle later.
    do_reset();
    setup(32'd3, 32'h21, "cont_setup");
    cyc(1'b1, 12'h100, 32'hA, "cont_cpu0");
    cyc(1'b1, 12'h100, 32'hB, "cont_cpu1");
    cyc(1'b1, 12'h100, 32'hC, "cont_cpu2");
    check("cont_last_cpu_fwd", {dvo_wr_e, dvo_addr, dvo_data}, {1'b1, 12'h100, 32'hC});
    cyc(1'b0, '0, '0, "cont_emit");
    check("cont_emit_after", {dvo_wr_e, dvo_addr, dvo_data}, {1'b1, A_LED, 32'h1});

    // Loop: 1,2,4,1,2,... then stop with ctrl=0.
    do_reset();
    setup(32'd3, 32'h23, "loop_setup");
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, '0, '0, "loop_run");
      if (dvo_wr_e && dvo_addr == A_LED) got_q.push_back(dvo_data);
    end
    check("loop_emit_count", got_q.size(), 5);
    for (int k = 0; k < 5; k++)
      if (got_q.size() > k) check($sformatf("loop_emit[%0d]", k), got_q[k], exp_loop[k]);
    cyc(1'b1, A_CTRL, 32'h0, "loop_stop");
    writes = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, '0, '0, "loop_stopped");
      if (dvo_wr_e) writes++;
    end
    check("loop_no_writes_after_stop", writes, 0);
    check("loop_data_held", dvo_data, 32'h0);
    check("loop_not_busy", seq_busy, 1'b0);

    // Period 0 behaves like period 1: emits two cycles apart.
    do_reset();
    setup(32'd0, 32'h11, "p0_setup");
    at_q.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, '0, "p0_run");
      if (dvo_wr_e && dvo_addr == A_LED) at_q.push_back(i);
    end
    check("p0_emit_count", at_q.size(), 2);
    if (at_q.size() >= 2) check("p0_spacing", at_q[1] - at_q[0], 2);

    // Live pattern update while looping.
    do_reset();
    setup(32'd1, 32'h23, "live_setup");
    repeat (3) cyc(1'b0, '0, '0, "live_pre");
    cyc(1'b1, A_PAT + 12'd4, 32'h00AB_CDEF, "live_wr");
    found = 0; got = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, '0, '0, "live_run");
      if (!found && dvo_wr_e && dvo_addr == A_LED && seq_idx == 3'd1) begin
        found = 1; got = dvo_data;
      end
    end
    check("live_found", found, 1'b1);
    check("live_data", got, 32'h00AB_CDEF);

    // Asynchronous reset mid-WAIT.
    do_reset();
    setup(32'd3, 32'h21, "ar_setup");
    repeat (2) cyc(1'b0, '0, '0, "ar_pre");
    #3 rst_n = 1'b0;
    #1 check("async_reset_outputs", outs_act(), 64'h0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    writes = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, '0, '0, "ar_post");
      if (dvo_wr_e) writes++;
    end
    check("ar_no_writes", writes, 0);

    // Random bus traffic against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [11:0] a;
      logic [31:0] d;
      if ($urandom_range(0, 99) < 20) begin
        d = $urandom;
        case ($urandom_range(0, 5))
          0: begin a = A_CTRL; d[0] = ($urandom_range(0, 3) != 0); end
          1: begin a = A_PER; d = (d & 32'hFF00_0000) | $urandom_range(0, 4); end
          2: a = A_PAT + 12'($urandom_range(0, 7) * 4);
          3: a = A_LED;
          4: a = 12'h100;
          default: a = 12'($urandom_range(0, 4095));
        endcase
        cyc(1'b1, a, d, $sformatf("rand[%0d]", n));
      end else begin
        cyc(1'b0, '0, '0, $sformatf("rand[%0d]", n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
